// File: rtl/btn_cond_pkg.sv
// Shared types and default constants for the push-button conditioning path.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_HELD   = 2'd2,
        ST_DISARM = 2'd3
    } btn_state_e;

    // Which interval the auto-repeat counter is currently timing.
    typedef enum logic {
        PH_DELAY = 1'b0,
        PH_RATE  = 1'b1
    } rpt_phase_e;

    localparam int unsigned DEF_NUM_BTN         = 5;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
    localparam int unsigned DEF_REPEAT_RATE     = 10_000_000;
    localparam int unsigned DEF_CNT_W           = 26;

endpackage

// File: rtl/button_debounce_fsm.sv
// One button: 2-flop synchronizer, debounce FSM, press/release pulses and hold-to-repeat pulses.
module button_debounce_fsm
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam logic [CNT_W-1:0] LP_DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_DELAY_LAST = CNT_W'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
    localparam logic [CNT_W-1:0] LP_RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic             LP_RPT_EN     = (REPEAT_DELAY > 0);

    btn_state_e       r_state;
    rpt_phase_e       r_phase;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_rpt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_repeat;

    logic [CNT_W-1:0] w_rpt_last;
    logic             w_rpt_hit;

    assign w_rpt_last = (r_phase == PH_RATE) ? LP_RATE_LAST : LP_DELAY_LAST;
    assign w_rpt_hit  = (r_rpt == w_rpt_last);

    // Pulses default low every cycle; only one FSM branch can raise one of them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_phase   <= PH_DELAY;
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_rpt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_sync1   <= i_btn_raw;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_sync2) begin
                        r_state <= ST_ARM;
                        r_cnt   <= '0;
                    end
                end
                ST_ARM: begin
                    if (!r_sync2) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == LP_DEB_LAST) begin
                        r_state <= ST_HELD;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                        r_rpt   <= '0;
                        r_phase <= PH_DELAY;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!r_sync2) begin
                        r_state <= ST_DISARM;
                        r_cnt   <= '0;
                    end else if (LP_RPT_EN) begin
                        if (w_rpt_hit) begin
                            r_repeat <= 1'b1;
                            r_rpt    <= '0;
                            r_phase  <= PH_RATE;
                        end else begin
                            r_rpt <= r_rpt + CNT_W'(1);
                        end
                    end
                end
                ST_DISARM: begin
                    // Repeat counter and phase are left untouched so a rejected glitch resumes timing.
                    if (r_sync2) begin
                        r_state <= ST_HELD;
                    end else if (r_cnt == LP_DEB_LAST) begin
                        r_state   <= ST_IDLE;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = r_repeat;

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTN raw board push-buttons into clean clk-synchronous levels and event pulses.
module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    // Buttons are fully independent; each bit gets its own conditioner.
    for (genvar gi = 0; gi < int'(NUM_BTN); gi++) begin : g_btn
        button_debounce_fsm #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .CNT_W           (CNT_W)
        ) u_btn (
            .clk       (clk),
            .rst       (rst),
            .i_btn_raw (btn_raw[gi]),
            .o_level   (btn_level[gi]),
            .o_press   (btn_press[gi]),
            .o_release (btn_release[gi]),
            .o_repeat  (btn_repeat[gi])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner against a run-length behavioural model.
module tb_button_conditioner;

    localparam int NB    = 5;
    localparam int DEB   = 4;
    localparam int RDLY  = 10;
    localparam int RRATE = 3;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_repeat;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RDLY),
        .REPEAT_RATE     (RRATE),
        .CNT_W           (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: the level flips once the input seen two edges late has disagreed with it for
    // DEB+1 consecutive samples; repeats follow from a count of steady held samples.
    bit            m_d1  [NB];
    bit            m_d2  [NB];
    bit            m_lvl [NB];
    int            m_run [NB];
    int            m_act [NB];
    bit            m_x;
    logic [NB-1:0] e_level   = '0;
    logic [NB-1:0] e_press   = '0;
    logic [NB-1:0] e_release = '0;
    logic [NB-1:0] e_repeat  = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NB; i++) begin
                m_d1[i] = 1'b0; m_d2[i] = 1'b0; m_lvl[i] = 1'b0;
                m_run[i] = 0;   m_act[i] = 0;
            end
            e_level = '0; e_press = '0; e_release = '0; e_repeat = '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                m_x      = m_d2[i];
                m_d2[i]  = m_d1[i];
                m_d1[i]  = btn_raw[i];
                e_press[i]   = 1'b0;
                e_release[i] = 1'b0;
                e_repeat[i]  = 1'b0;
                if (m_x != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB + 1) begin
                        m_lvl[i] = m_x;
                        m_run[i] = 0;
                        if (m_x) begin
                            e_press[i] = 1'b1;
                            m_act[i]   = 0;
                        end else begin
                            e_release[i] = 1'b1;
                        end
                    end
                end else begin
                    if (m_lvl[i] && m_run[i] == 0) begin
                        m_act[i]++;
                        if (m_act[i] == RDLY || (m_act[i] > RDLY && (m_act[i] - RDLY) % RRATE == 0))
                            e_repeat[i] = 1'b1;
                    end
                    m_run[i] = 0;
                end
                e_level[i] = m_lvl[i];
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("level",   32'(btn_level),   32'(e_level));
            chk("press",   32'(btn_press),   32'(e_press));
            chk("release", 32'(btn_release), 32'(e_release));
            chk("repeat",  32'(btn_repeat),  32'(e_repeat));
            chk("mutex",   32'((btn_press & btn_release) | (btn_press & btn_repeat) | (btn_release & btn_repeat)), 32'(0));
        end
    end

    task automatic wait_press(input int b, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (btn_press[b]) ok = 1'b1;
        end
        chk("press_timeout", 32'(ok), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            ok;
        bit            seen;
        bit            seen2;
        int            rel_cnt;
        int            lim;
        logic [NB-1:0] obs;

        repeat (3) @(negedge clk);
        chk("rst_level",   32'(btn_level),   32'(0));
        chk("rst_press",   32'(btn_press),   32'(0));
        chk("rst_release", 32'(btn_release), 32'(0));
        chk("rst_repeat",  32'(btn_repeat),  32'(0));
        rst    = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Clean press: raw sampled high at edge 0, press visible after edge 6.
        btn_raw[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("t1_early", 32'(btn_press), 32'(0));
        @(negedge clk);
        chk("t1_press", 32'(btn_press), 32'(5'b00001));
        chk("t1_level", 32'(btn_level), 32'(5'b00001));
        @(negedge clk);
        chk("t1_pulse_end", 32'(btn_press), 32'(0));
        btn_raw[0] = 1'b0;
        repeat (10) @(negedge clk);

        // Bounce on bit 1 never accepted.
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            btn_raw[1] = (k % 2 == 0);
            repeat (2) begin
                @(negedge clk);
                seen |= btn_press[1] | btn_level[1];
            end
        end
        btn_raw[1] = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= btn_press[1] | btn_level[1];
        end
        chk("t2_bounce", 32'(seen), 32'(0));

        // Auto-repeat on bit 2.
        btn_raw[2] = 1'b1;
        wait_press(2, ok);
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            chk("t3_repeat", 32'(btn_repeat[2]), 32'(j >= 10 && (j - 10) % 3 == 0));
        end
        btn_raw[2] = 1'b0;
        rel_cnt = 0;
        repeat (14) begin
            @(negedge clk);
            if (btn_release[2]) rel_cnt++;
        end
        chk("t3_release_cnt", 32'(rel_cnt), 32'(1));
        chk("t3_level_low",   32'(btn_level[2]), 32'(0));

        // Release glitch on bit 3 rejected.
        btn_raw[3] = 1'b1;
        wait_press(3, ok);
        repeat (3) @(negedge clk);
        btn_raw[3] = 1'b0;
        repeat (2) @(negedge clk);
        btn_raw[3] = 1'b1;
        seen = 1'b0; seen2 = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen  |= btn_release[3];
            seen2 |= ~btn_level[3];
        end
        chk("t4_no_release", 32'(seen),  32'(0));
        chk("t4_level_kept", 32'(seen2), 32'(0));
        btn_raw[3] = 1'b0;
        repeat (10) @(negedge clk);

        // Simultaneous presses.
        btn_raw = 5'b10101;
        repeat (6) @(negedge clk);
        chk("t5_early", 32'(btn_press), 32'(0));
        @(negedge clk);
        chk("t5_press", 32'(btn_press), 32'(5'b10101));
        btn_raw = '0;
        repeat (12) @(negedge clk);

        // Async reset mid-hold.
        btn_raw[0] = 1'b1;
        wait_press(0, ok);
        repeat (2) @(negedge clk);
        chk("t6_held", 32'(btn_level[0]), 32'(1));
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        obs = btn_level | btn_press | btn_release | btn_repeat;
        chk("t6_async_clear", 32'(obs), 32'(0));
        btn_raw = '0;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= |(btn_release | btn_level);
        end
        chk("t6_no_release", 32'(seen), 32'(0));
        btn_raw[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("t6_repress_early", 32'(btn_press), 32'(0));
        @(negedge clk);
        chk("t6_repress", 32'(btn_press), 32'(5'b00001));
        btn_raw = '0;
        repeat (10) @(negedge clk);

        // Random phase: per-block flip odds vary from bouncy to long holds.
        for (int blk = 0; blk < 20; blk++) begin
            lim = int'($urandom_range(3, 40));
            repeat (80) begin
                @(negedge clk);
                for (int b = 0; b < NB; b++)
                    if ($urandom_range(0, lim) == 0) btn_raw[b] = ~btn_raw[b];
            end
        end
        btn_raw = '0;
        repeat (12) @(negedge clk);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
